// File: rtl/core_savestate_pkg.sv
// Shared types and helpers for the savestate engine: FSM state encoding,
// operation select, and the savestate-window address decode.
package core_savestate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACK    = 3'd1,
    ST_PAUSE  = 3'd2,
    ST_XFER   = 3'd3,
    ST_RESUME = 3'd4
  } state_e;

  typedef enum logic {
    OP_SAVE = 1'b0,
    OP_LOAD = 1'b1
  } op_e;

  typedef struct packed {
    logic        hit;     // address falls inside the window
    logic [15:0] offset;  // word index relative to the window base
  } win_t;

  // Decode a bridge byte address against a word-sized window. The subtraction
  // is done first so that base + size never has to be formed (no overflow).
  function automatic win_t win_decode(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] words);
    logic [31:0] diff;
    win_t        res;
    diff       = addr - base;
    res.hit    = (addr >= base) && (diff < (words << 2));
    res.offset = 16'(diff >> 2);
    return res;
  endfunction

endpackage

// File: rtl/core_savestate_ctrl_if.sv
// Savestate engine bus bundle: command-handler handshake, bridge access,
// core pause handshake and the state-memory port.
// slave = engine side, master = environment side.
interface core_savestate_ctrl_if;

  logic        savestate_start;
  logic        savestate_load;
  logic        savestate_start_ack;
  logic        savestate_start_busy;
  logic        savestate_start_ok;
  logic        savestate_start_err;
  logic        savestate_load_ack;
  logic        savestate_load_busy;
  logic        savestate_load_ok;
  logic        savestate_load_err;
  logic [31:0] savestate_addr;
  logic [31:0] savestate_size;
  logic [31:0] savestate_maxloadsize;

  logic [31:0] bridge_addr;
  logic        bridge_rd;
  logic        bridge_wr;
  logic [31:0] bridge_wr_data;
  logic [31:0] bridge_rd_data;

  logic        core_pause_req;
  logic        core_paused;

  logic [15:0] ss_addr;
  logic        ss_rd;
  logic [31:0] ss_rd_data;
  logic        ss_wr;
  logic [31:0] ss_wr_data;

  modport slave (
    input  savestate_start, savestate_load,
    output savestate_start_ack, savestate_start_busy, savestate_start_ok, savestate_start_err,
    output savestate_load_ack, savestate_load_busy, savestate_load_ok, savestate_load_err,
    output savestate_addr, savestate_size, savestate_maxloadsize,
    input  bridge_addr, bridge_rd, bridge_wr, bridge_wr_data,
    output bridge_rd_data,
    output core_pause_req,
    input  core_paused,
    output ss_addr, ss_rd, ss_wr, ss_wr_data,
    input  ss_rd_data
  );

  modport master (
    output savestate_start, savestate_load,
    input  savestate_start_ack, savestate_start_busy, savestate_start_ok, savestate_start_err,
    input  savestate_load_ack, savestate_load_busy, savestate_load_ok, savestate_load_err,
    input  savestate_addr, savestate_size, savestate_maxloadsize,
    output bridge_addr, bridge_rd, bridge_wr, bridge_wr_data,
    input  bridge_rd_data,
    input  core_pause_req,
    output core_paused,
    input  ss_addr, ss_rd, ss_wr, ss_wr_data,
    output ss_rd_data
  );

endinterface

// File: rtl/core_savestate_ctrl.sv
// Savestate engine: turns start/load request edges into a paused-core window
// during which the host reads (save) or writes (load) SS_WORDS state words
// through the bridge. Optional idle timeout: CORE_SAVESTATE_TIMEOUT_EN.
module core_savestate_ctrl
  import core_savestate_pkg::*;
#(
  parameter logic [31:0] SS_ADDR     = 32'h4000_0000,
  parameter int unsigned SS_WORDS    = 1024,
  parameter logic [23:0] TIMEOUT_CYC = 24'hFF_FFFF
) (
  input  logic                 clk,
  input  logic                 reset,
  core_savestate_ctrl_if.slave bus
);

  localparam logic [31:0] WORDS_C = 32'(SS_WORDS);
  localparam logic [31:0] SIZE_C  = 32'(SS_WORDS * 4);
  localparam logic [16:0] CNT_END = 17'(SS_WORDS);

  state_e      state_r;
  op_e         op_r;
  logic        start_q_r;
  logic        load_q_r;
  logic        pend_save_r;
  logic        pend_load_r;
  logic [16:0] cnt_r;
  logic        s_ack_r, s_busy_r, s_ok_r;
  logic        l_ack_r, l_busy_r, l_ok_r;
  logic        pause_req_r;
  logic [15:0] ss_addr_r;
  logic        ss_rd_r;
  logic        ss_wr_r;
  logic [31:0] ss_wr_data_r;
  logic [31:0] rd_data_r;

  logic        start_edge_s;
  logic        load_edge_s;
  win_t        win_s;
  logic        rd_hit_s;
  logic        wr_hit_s;

  assign start_edge_s = bus.savestate_start & ~start_q_r;
  assign load_edge_s  = bus.savestate_load & ~load_q_r;
  assign win_s        = win_decode(bus.bridge_addr, SS_ADDR, WORDS_C);
  assign rd_hit_s     = bus.bridge_rd & win_s.hit;
  assign wr_hit_s     = bus.bridge_wr & win_s.hit;

`ifdef CORE_SAVESTATE_TIMEOUT_EN
  logic        s_err_r;
  logic        l_err_r;
  logic [23:0] tmo_r;
  logic        counted_s;

  // A counted access is a captured save word or an accepted load word.
  assign counted_s = ss_rd_r |
                     ((state_r == ST_XFER) && (op_r == OP_LOAD) && wr_hit_s && (cnt_r < CNT_END));
`endif

  // Remember previous request levels for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q_r <= 1'b0;
      load_q_r  <= 1'b0;
    end else begin
      start_q_r <= bus.savestate_start;
      load_q_r  <= bus.savestate_load;
    end
  end

  // Capture state-memory read data the cycle after the engine issued ss_rd.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_r <= 32'h0000_0000;
    end else if (ss_rd_r) begin
      rd_data_r <= bus.ss_rd_data;
    end
  end

  // Engine FSM: pending flags, handshake outputs, word counter and memory port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      op_r         <= OP_SAVE;
      pend_save_r  <= 1'b0;
      pend_load_r  <= 1'b0;
      cnt_r        <= 17'd0;
      s_ack_r      <= 1'b0;
      s_busy_r     <= 1'b0;
      s_ok_r       <= 1'b0;
      l_ack_r      <= 1'b0;
      l_busy_r     <= 1'b0;
      l_ok_r       <= 1'b0;
      pause_req_r  <= 1'b0;
      ss_addr_r    <= 16'h0000;
      ss_rd_r      <= 1'b0;
      ss_wr_r      <= 1'b0;
      ss_wr_data_r <= 32'h0000_0000;
`ifdef CORE_SAVESTATE_TIMEOUT_EN
      s_err_r      <= 1'b0;
      l_err_r      <= 1'b0;
      tmo_r        <= 24'd0;
`endif
    end else begin
      s_ack_r     <= 1'b0;
      l_ack_r     <= 1'b0;
      ss_rd_r     <= 1'b0;
      ss_wr_r     <= 1'b0;
      pend_save_r <= pend_save_r | start_edge_s;
      pend_load_r <= pend_load_r | load_edge_s;
      // A save word is counted when its data is captured.
      if (ss_rd_r) begin
        cnt_r <= cnt_r + 17'd1;
      end

      case (state_r)
        ST_IDLE: begin
          // Save wins when both are pending; the load flag stays latched.
          if (pend_save_r) begin
            pend_save_r <= start_edge_s;
            op_r        <= OP_SAVE;
            s_ack_r     <= 1'b1;
            s_busy_r    <= 1'b1;
            s_ok_r      <= 1'b0;
`ifdef CORE_SAVESTATE_TIMEOUT_EN
            s_err_r     <= 1'b0;
`endif
            pause_req_r <= 1'b1;
            cnt_r       <= 17'd0;
            state_r     <= ST_ACK;
          end else if (pend_load_r) begin
            pend_load_r <= load_edge_s;
            op_r        <= OP_LOAD;
            l_ack_r     <= 1'b1;
            l_busy_r    <= 1'b1;
            l_ok_r      <= 1'b0;
`ifdef CORE_SAVESTATE_TIMEOUT_EN
            l_err_r     <= 1'b0;
`endif
            pause_req_r <= 1'b1;
            cnt_r       <= 17'd0;
            state_r     <= ST_ACK;
          end
        end
        ST_ACK: begin
          state_r <= ST_PAUSE;
        end
        ST_PAUSE: begin
          if (bus.core_paused) begin
            state_r <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (cnt_r >= CNT_END) begin
            pause_req_r <= 1'b0;
            state_r     <= ST_RESUME;
          end else if (op_r == OP_SAVE) begin
            if (rd_hit_s) begin
              ss_rd_r   <= 1'b1;
              ss_addr_r <= win_s.offset;
            end
          end else if (wr_hit_s) begin
            ss_wr_r      <= 1'b1;
            ss_addr_r    <= win_s.offset;
            ss_wr_data_r <= bus.bridge_wr_data;
            cnt_r        <= cnt_r + 17'd1;
          end
        end
        ST_RESUME: begin
          if (!bus.core_paused) begin
            if (op_r == OP_SAVE) begin
              s_ok_r   <= 1'b1;
              s_busy_r <= 1'b0;
            end else begin
              l_ok_r   <= 1'b1;
              l_busy_r <= 1'b0;
            end
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

`ifdef CORE_SAVESTATE_TIMEOUT_EN
      // Idle watchdog: reload on ACK and on progress, abort the op at zero.
      if (state_r == ST_ACK) begin
        tmo_r <= TIMEOUT_CYC;
      end else if ((state_r == ST_PAUSE) || (state_r == ST_XFER) || (state_r == ST_RESUME)) begin
        if (tmo_r == 24'd0) begin
          if (op_r == OP_SAVE) begin
            s_err_r  <= 1'b1;
            s_ok_r   <= 1'b0;
            s_busy_r <= 1'b0;
          end else begin
            l_err_r  <= 1'b1;
            l_ok_r   <= 1'b0;
            l_busy_r <= 1'b0;
          end
          pause_req_r <= 1'b0;
          ss_rd_r     <= 1'b0;
          ss_wr_r     <= 1'b0;
          state_r     <= ST_IDLE;
        end else if (counted_s) begin
          tmo_r <= TIMEOUT_CYC;
        end else begin
          tmo_r <= tmo_r - 24'd1;
        end
      end
`endif
    end
  end

  assign bus.savestate_start_ack   = s_ack_r;
  assign bus.savestate_start_busy  = s_busy_r;
  assign bus.savestate_start_ok    = s_ok_r;
  assign bus.savestate_load_ack    = l_ack_r;
  assign bus.savestate_load_busy   = l_busy_r;
  assign bus.savestate_load_ok     = l_ok_r;
`ifdef CORE_SAVESTATE_TIMEOUT_EN
  assign bus.savestate_start_err   = s_err_r;
  assign bus.savestate_load_err    = l_err_r;
`else
  assign bus.savestate_start_err   = 1'b0;
  assign bus.savestate_load_err    = 1'b0;
`endif
  assign bus.savestate_addr        = SS_ADDR;
  assign bus.savestate_size        = SIZE_C;
  assign bus.savestate_maxloadsize = SIZE_C;
  assign bus.bridge_rd_data        = rd_data_r;
  assign bus.core_pause_req        = pause_req_r;
  assign bus.ss_addr               = ss_addr_r;
  assign bus.ss_rd                 = ss_rd_r;
  assign bus.ss_wr                 = ss_wr_r;
  assign bus.ss_wr_data            = ss_wr_data_r;

endmodule

// File: tb/tb_core_savestate_ctrl.sv
// Bench for core_savestate_ctrl (SS_WORDS=4, TIMEOUT_CYC=100). Stimulus tasks
// schedule the expected ack / ss_rd / ss_wr / read-data events per cycle from
// the handshake latencies; one negedge process compares every cycle.
module tb_core_savestate_ctrl;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_savestate_ctrl_if bus();

  core_savestate_ctrl #(
    .SS_ADDR    (BASE),
    .SS_WORDS   (4),
    .TIMEOUT_CYC(24'd100)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Expected events keyed by the cycle in which they must be visible.
  bit          exp_sack[int];
  bit          exp_lack[int];
  logic [15:0] exp_rd[int];
  logic [47:0] exp_wr[int];
  logic [31:0] exp_rdata[int];
  logic [31:0] model_rdata = 32'h0;

  logic [31:0] mem [0:3];
  assign bus.ss_rd_data = (bus.ss_addr < 16'd4) ? mem[bus.ss_addr[1:0]] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Per-cycle comparison against the scheduled events.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("start_ack", 48'(bus.savestate_start_ack), 48'(exp_sack.exists(cyc)));
      chk("load_ack", 48'(bus.savestate_load_ack), 48'(exp_lack.exists(cyc)));
      chk("ss_rd", 48'(bus.ss_rd), 48'(exp_rd.exists(cyc)));
      if (exp_rd.exists(cyc)) chk("ss_rd_addr", 48'(bus.ss_addr), 48'(exp_rd[cyc]));
      chk("ss_wr", 48'(bus.ss_wr), 48'(exp_wr.exists(cyc)));
      if (exp_wr.exists(cyc)) chk("ss_wr_addr_data", {bus.ss_addr, bus.ss_wr_data}, exp_wr[cyc]);
      if (exp_rdata.exists(cyc)) model_rdata = exp_rdata[cyc];
      chk("bridge_rd_data", 48'(bus.bridge_rd_data), 48'(model_rdata));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Called in the ack cycle: pause the core, move 4 words, resume, check ok.
  // junk adds two accesses that must be ignored (out-of-window / wrong direction).
  task automatic serve(input bit is_load, input logic [31:0] base_data, input bit junk);
    chk("pause_req_at_ack", 48'(bus.core_pause_req), 48'h1);
    chk("busy_at_ack", 48'(is_load ? bus.savestate_load_busy : bus.savestate_start_busy), 48'h1);
    bus.core_paused = 1'b1;
    steps(2);
    if (junk) begin
      if (is_load) begin
        bus.bridge_wr = 1'b1; bus.bridge_addr = BASE + 32'd16; bus.bridge_wr_data = 32'hBAD0_0001;
        step();
        bus.bridge_wr = 1'b0; bus.bridge_rd = 1'b1; bus.bridge_addr = BASE;
        step();
      end else begin
        bus.bridge_rd = 1'b1; bus.bridge_addr = BASE - 32'd4;
        step();
        bus.bridge_rd = 1'b0; bus.bridge_wr = 1'b1; bus.bridge_addr = BASE + 32'd4;
        bus.bridge_wr_data = 32'hBAD0_0002;
        step();
      end
      bus.bridge_rd = 1'b0; bus.bridge_wr = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      bus.bridge_addr = BASE + 32'(4 * i);
      if (is_load) begin
        bus.bridge_wr = 1'b1;
        bus.bridge_wr_data = base_data + 32'(i);
        exp_wr[cyc + 1] = {16'(i), base_data + 32'(i)};
      end else begin
        bus.bridge_rd = 1'b1;
        exp_rd[cyc + 1] = 16'(i);
        exp_rdata[cyc + 2] = mem[i];
      end
      step();
    end
    bus.bridge_rd = 1'b0; bus.bridge_wr = 1'b0; bus.bridge_addr = 32'h0;
    chk("pause_req_hold", 48'(bus.core_pause_req), 48'h1);
    if (!is_load) begin
      step();
      chk("pause_req_hold2", 48'(bus.core_pause_req), 48'h1);
    end
    step();
    chk("pause_req_release", 48'(bus.core_pause_req), 48'h0);
    chk("ok_before_unpause", 48'(is_load ? bus.savestate_load_ok : bus.savestate_start_ok), 48'h0);
    bus.core_paused = 1'b0;
    step();
    chk("ok_after_unpause", 48'(is_load ? bus.savestate_load_ok : bus.savestate_start_ok), 48'h1);
    chk("busy_after_unpause", 48'(is_load ? bus.savestate_load_busy : bus.savestate_start_busy), 48'h0);
  endtask

  int c;
  int a;

  initial begin
    mem[0] = 32'hA000_00A0; mem[1] = 32'hA000_00A1;
    mem[2] = 32'hA000_00A2; mem[3] = 32'hA000_00A3;
    bus.savestate_start = 1'b0; bus.savestate_load = 1'b0;
    bus.bridge_addr = 32'h0; bus.bridge_rd = 1'b0; bus.bridge_wr = 1'b0;
    bus.bridge_wr_data = 32'h0; bus.core_paused = 1'b0;
    reset = 1'b0;
    #2 reset = 1'b1;
    steps(3);
    chk("rst_pause_req", 48'(bus.core_pause_req), 48'h0);
    chk("rst_busy_ok", 48'({bus.savestate_start_busy, bus.savestate_start_ok, bus.savestate_load_busy,
                             bus.savestate_load_ok, bus.savestate_start_err, bus.savestate_load_err}), 48'h0);
    chk("rst_ss_port", 48'({bus.ss_rd, bus.ss_wr, bus.ss_addr}), 48'h0);
    chk("const_addr", 48'(bus.savestate_addr), 48'h4000_0000);
    chk("const_size", 48'(bus.savestate_size), 48'd16);
    chk("const_maxload", 48'(bus.savestate_maxloadsize), 48'd16);
    reset = 1'b0;
    step();
    chk_en = 1'b1;

    // Save of 4 words.
    c = cyc; bus.savestate_start = 1'b1; exp_sack[c + 2] = 1'b1;
    steps(2);
    serve(1'b0, 32'h0, 1'b0);
    chk("save_last_word", 48'(bus.bridge_rd_data), 48'hA000_00A3);
    bus.savestate_start = 1'b0;

    // Load of 4 words.
    c = cyc; bus.savestate_load = 1'b1; exp_lack[c + 2] = 1'b1;
    steps(2);
    serve(1'b1, 32'h1122_3344, 1'b0);
    chk("load_last_data", 48'(bus.ss_wr_data), 48'h1122_3347);
    chk("save_ok_persists", 48'(bus.savestate_start_ok), 48'h1);
    bus.savestate_load = 1'b0;
    step();

    // Simultaneous edges: save first (with ignored accesses), then load.
    c = cyc; bus.savestate_start = 1'b1; bus.savestate_load = 1'b1; exp_sack[c + 2] = 1'b1;
    steps(2);
    serve(1'b0, 32'h0, 1'b1);
    exp_lack[cyc + 1] = 1'b1;
    step();
    serve(1'b1, 32'h5566_7788, 1'b1);
    bus.savestate_start = 1'b0; bus.savestate_load = 1'b0;
    step();

    // Core never pauses.
    c = cyc; bus.savestate_start = 1'b1; exp_sack[c + 2] = 1'b1;
    steps(2);
    a = cyc;
`ifdef CORE_SAVESTATE_TIMEOUT_EN
    for (int i = 0; i < 200 && !bus.savestate_start_err; i++) step();
    chk("timeout_err", 48'(bus.savestate_start_err), 48'h1);
    chk("timeout_latency_ok", 48'((cyc - a >= 99) && (cyc - a <= 104)), 48'h1);
    chk("timeout_pause_req", 48'(bus.core_pause_req), 48'h0);
    chk("timeout_busy", 48'(bus.savestate_start_busy), 48'h0);
`else
    steps(150);
    chk("no_timeout_err", 48'(bus.savestate_start_err), 48'h0);
    chk("no_timeout_pause_req", 48'(bus.core_pause_req), 48'h1);
    chk("no_timeout_busy", 48'(bus.savestate_start_busy), 48'h1);
    serve(1'b0, 32'h0, 1'b0);
`endif
    bus.savestate_start = 1'b0;
    step();

    // Reset during transfer after two words.
    c = cyc; bus.savestate_start = 1'b1; exp_sack[c + 2] = 1'b1;
    steps(2);
    bus.core_paused = 1'b1;
    steps(2);
    for (int i = 0; i < 2; i++) begin
      bus.bridge_addr = BASE + 32'(4 * i); bus.bridge_rd = 1'b1;
      exp_rd[cyc + 1] = 16'(i); exp_rdata[cyc + 2] = mem[i];
      step();
    end
    bus.bridge_rd = 1'b0;
    step();
    chk("pre_reset_data", 48'(bus.bridge_rd_data), 48'hA000_00A1);
    chk_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", 48'(bus.savestate_start_busy), 48'h0);
    chk("rst_mid_load_ok", 48'(bus.savestate_load_ok), 48'h0);
    chk("rst_mid_pause_req", 48'(bus.core_pause_req), 48'h0);
    chk("rst_mid_rd_data", 48'(bus.bridge_rd_data), 48'h0);
    bus.savestate_start = 1'b0; bus.core_paused = 1'b0;
    exp_rd.delete(); exp_rdata.delete(); exp_wr.delete();
    model_rdata = 32'h0;
    step();
    reset = 1'b0;
    step();
    chk_en = 1'b1;
    c = cyc; bus.savestate_start = 1'b1; exp_sack[c + 2] = 1'b1;
    steps(2);
    serve(1'b0, 32'h0, 1'b0);
    bus.savestate_start = 1'b0;
    steps(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
